// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline front end: data widths, PC step,
// the NOP encoding and the fetch control state encoding.
package pipeline_pkg;

  localparam int INSTR_WIDTH = 32;
  localparam int ADDR_WIDTH  = 32;

  // Every instruction occupies one 32-bit word.
  localparam logic [31:0] PC_STEP = 32'd4;

  // All-zero word; the instruction buffer resets to this value.
  localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0;

  // IDLE  : one cycle after reset before fetching starts
  // FETCH : issuing requests and buffering responses
  // FLUSH : waiting for wrong-path responses to drain after a redirect
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer between fetch and decode. Each entry holds {pc, instr}.
// The head entry is read combinationally so a word written in cycle t is
// visible at the output in cycle t+1. Push and pop in the same cycle are
// allowed when full (count holds) and when empty (write lands, pop ignored).
module fetch_fifo
  import pipeline_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic [WIDTH-1:0]            din,
  input  logic                        pop,
  input  logic                        flush,
  output logic [WIDTH-1:0]            dout,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [WIDTH-1:0] EMPTY_ENTRY = WIDTH'(NOP_INSTR);

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [WIDTH-1:0] entry_data [FIFO_DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == DEPTH_CNT);
  assign count = count_reg;

  // A flush discards everything, so it suppresses both pointer moves.
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);

  assign dout = entry_data[rd_ptr_reg];

  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
    logic [WIDTH-1:0] data_reg;

    // Capture the incoming word when the write pointer selects this slot.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_reg <= EMPTY_ENTRY;
      end else if (do_push && (wr_ptr_reg == PTR_W'(gi))) begin
        data_reg <= din;
      end
    end

    assign entry_data[gi] = data_reg;
  end

  // Pointer and occupancy bookkeeping; the depth is a power of two so the
  // pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // The fetch credit scheme must never offer a word to a full buffer unless
  // the head leaves in the same cycle.
  overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !flush && full && !pop));

endmodule

// File: rtl/instruction_fetch.sv
// Front stage of the pipeline. Owns the PC, issues in-order word requests
// to instruction memory, buffers returned words with their PC and hands them
// to decode. A redirect flushes the buffer, reloads the PC and marks every
// request still in flight as wrong-path so its response is dropped.
module instruction_fetch #(
  parameter int                    ADDR_WIDTH = pipeline_pkg::ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  output logic                                imem_req,
  output logic [ADDR_WIDTH-1:0]               imem_addr,
  input  logic                                imem_gnt,
  input  logic                                imem_rvalid,
  input  logic [pipeline_pkg::INSTR_WIDTH-1:0] imem_rdata,
  output logic [pipeline_pkg::INSTR_WIDTH-1:0] instruction,
  output logic [ADDR_WIDTH-1:0]               instr_pc,
  output logic                                instr_valid,
  input  logic                                stall,
  input  logic                                redirect,
  input  logic [ADDR_WIDTH-1:0]               redirect_pc
);

  import pipeline_pkg::*;

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int FIFO_W = ADDR_WIDTH + INSTR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(PC_STEP);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);
  localparam logic [CNT_W:0]        CREDIT_MAX = (CNT_W+1)'(FIFO_DEPTH);

  fetch_state_e          state_reg;
  logic [ADDR_WIDTH-1:0] pc_reg;
  logic [ADDR_WIDTH-1:0] resp_pc_reg;
  logic [CNT_W-1:0]      outstanding_reg;
  logic [CNT_W-1:0]      outstanding_next;
  logic [CNT_W-1:0]      discard_cnt_reg;
  logic [CNT_W-1:0]      discard_cnt_next;

  logic                  credit_ok;
  logic                  req_granted;
  logic                  resp_discard;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic [FIFO_W-1:0]     fifo_din;
  logic [FIFO_W-1:0]     fifo_dout;
  logic [ADDR_WIDTH-1:0] redirect_target;

  // Low address bits of a redirect target are ignored.
  assign redirect_target = redirect_pc & ALIGN_MASK;

  // A request is only offered when a buffer slot is reserved for its response:
  // words in flight plus words buffered must stay below the depth.
  assign credit_ok   = ({1'b0, outstanding_reg} + {1'b0, fifo_count}) < CREDIT_MAX;
  assign imem_req    = (state_reg == FETCH) && !redirect && credit_ok;
  assign imem_addr   = pc_reg;
  assign req_granted = imem_req && imem_gnt;

  // Responses owed to requests issued before a redirect are wrong-path.
  assign resp_discard = (discard_cnt_reg != '0);
  assign fifo_push    = imem_rvalid && !redirect && !resp_discard;
  assign fifo_pop     = !fifo_empty && !stall && !redirect;
  assign fifo_din     = {resp_pc_reg, imem_rdata};

  assign instr_valid = !fifo_empty;
  assign instruction = fifo_dout[INSTR_WIDTH-1:0];
  assign instr_pc    = fifo_dout[FIFO_W-1:INSTR_WIDTH];

  // Granted-but-unanswered requests; every response retires one regardless of
  // whether it is kept or dropped.
  assign outstanding_next = outstanding_reg + CNT_W'(req_granted) - CNT_W'(imem_rvalid);

  // On a redirect every request still unanswered after this cycle becomes
  // wrong-path; otherwise each dropped response retires one of them.
  always_comb begin
    discard_cnt_next = discard_cnt_reg;
    if (redirect) begin
      discard_cnt_next = outstanding_next;
    end else if (imem_rvalid && resp_discard) begin
      discard_cnt_next = discard_cnt_reg - 1'b1;
    end
  end

  // Fetch control: leave IDLE after reset, sit in FLUSH while wrong-path
  // responses are still owed, fetch otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else if (redirect) begin
      state_reg <= (discard_cnt_next != '0) ? FLUSH : FETCH;
    end else begin
      case (state_reg)
        IDLE:    state_reg <= FETCH;
        FETCH:   state_reg <= FETCH;
        FLUSH:   state_reg <= (discard_cnt_next == '0) ? FETCH : FLUSH;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Request PC advances on grant; response PC advances on each kept word.
  // Both snap to the redirect target, which overrides everything else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg      <= RESET_PC;
      resp_pc_reg <= RESET_PC;
    end else if (redirect) begin
      pc_reg      <= redirect_target;
      resp_pc_reg <= redirect_target;
    end else begin
      if (req_granted) begin
        pc_reg <= pc_reg + STEP;
      end
      if (fifo_push) begin
        resp_pc_reg <= resp_pc_reg + STEP;
      end
    end
  end

  // In-flight and wrong-path counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding_reg <= '0;
      discard_cnt_reg <= '0;
    end else begin
      outstanding_reg <= outstanding_next;
      discard_cnt_reg <= discard_cnt_next;
    end
  end

  fetch_fifo #(
    .WIDTH      (FIFO_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .flush (redirect),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Memory must never answer more requests than were granted.
  no_orphan_resp_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_rvalid && (outstanding_reg == '0)));

  // A pending request keeps its address until granted or redirected.
  req_stable_a: assert property (@(posedge clk) disable iff (!rst_n)
    (imem_req && !imem_gnt) |=> (redirect || (imem_req && $stable(imem_addr))));

  // The credit rule reserves a slot for every response that will be kept.
  no_full_push_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(fifo_push && fifo_full && !fifo_pop));

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch. A memory model with random grant/latency feeds
// the design; a stream model (expected next delivered PC, buffered word count,
// epoch-tagged in-flight requests) predicts every observable output.
module tb_instruction_fetch;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          ready;
  } mem_req_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] instruction, instr_pc, redirect_pc;
  logic        instr_valid, stall, redirect;

  logic        w_req, w_rvalid, w_valid;
  logic [31:0] w_addr, w_rdata, w_instr, w_pc;

  always #5 clk = ~clk;

  instruction_fetch #(.ADDR_WIDTH(32), .RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instruction(instruction), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  instruction_fetch #(.ADDR_WIDTH(32), .RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(1'b1),
    .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
    .instruction(w_instr), .instr_pc(w_pc), .instr_valid(w_valid),
    .stall(1'b0), .redirect(1'b0), .redirect_pc(32'h0)
  );

  int checks = 0;
  int failures = 0;

  mem_req_t    pend[$];
  int          cyc, epoch, buf_cnt, last_ready, delivered;
  logic [31:0] exp_pc, exp_addr, prev_addr;
  bit          prev_wait, expect_req;
  int          p_gnt, p_stall, p_redir, min_lat, max_lat;
  bit          force_redir;
  logic [31:0] force_rpc;
  int          first_req_cyc, first_valid_cyc;
  bit          capt_req, capt_valid;
  logic [31:0] post_addr, post_pc;
  bit          w_pending, w_seen;
  logic [31:0] w_pend_addr, w_first_pc, w_first_instr;
  logic [31:0] w_addrs[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic int stale_count();
    int n = 0;
    foreach (pend[i]) if (pend[i].epoch != epoch) n++;
    return n;
  endfunction

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
    stall = 0; redirect = 0; redirect_pc = 0;
    w_rvalid = 0; w_rdata = 0;
    pend.delete(); epoch++; buf_cnt = 0; last_ready = 0;
    exp_pc = 0; exp_addr = 0; prev_wait = 0; expect_req = 0;
    first_req_cyc = -1; first_valid_cyc = -1;
    w_pending = 0; w_seen = 0; w_addrs.delete();
    repeat (n) @(posedge clk);
    #1;
    chk("rst_imem_req", imem_req, 0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_instruction", instruction, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_wrap_addr", w_addr, 32'hFFFF_FFF8);
    rst_n = 1'b1;
    cyc = 0;
  endtask

  // One clock cycle: drive memory/decode inputs, check outputs against the
  // stream model, then advance the model for the coming edge.
  task automatic step();
    mem_req_t r;
    bit       rv;
    int       rdy;
    rv = (pend.size() > 0) && (pend[0].ready <= cyc);
    imem_rvalid = rv;
    imem_rdata  = rv ? (pend[0].addr ^ 32'h0000_FFFF) : $urandom;
    imem_gnt    = ($urandom_range(99) < p_gnt);
    stall       = ($urandom_range(99) < p_stall);
    redirect    = force_redir || ($urandom_range(99) < p_redir);
    redirect_pc = force_redir ? force_rpc : $urandom;
    force_redir = 0;
    w_rvalid = w_pending;
    w_rdata  = w_pend_addr ^ 32'h0000_FFFF;
    #1;

    if (expect_req && !redirect) chk("req_resume", imem_req, 1);
    chk("instr_valid", instr_valid, buf_cnt > 0);
    if (buf_cnt > 0) begin
      chk("instr_pc", instr_pc, exp_pc);
      chk("instruction", instruction, exp_pc ^ 32'h0000_FFFF);
    end
    if (imem_req) begin
      chk("req_addr", imem_addr, exp_addr);
      chk("req_credit", (pend.size() + buf_cnt) < 2, 1);
      chk("req_in_flush", stale_count(), 0);
    end
    if (prev_wait && !redirect) begin
      chk("req_hold", imem_req, 1);
      chk("addr_hold", imem_addr, prev_addr);
    end
    if (redirect) chk("req_on_redirect", imem_req, 0);

    if (imem_req && first_req_cyc < 0) first_req_cyc = cyc;
    if (instr_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (capt_req && imem_req) begin capt_req = 0; post_addr = imem_addr; end
    if (capt_valid && instr_valid) begin capt_valid = 0; post_pc = instr_pc; end
    if (w_valid && !w_seen) begin w_seen = 1; w_first_pc = w_pc; w_first_instr = w_instr; end
    if (w_req && w_addrs.size() < 4) w_addrs.push_back(w_addr);
    w_pending   = w_req;
    w_pend_addr = w_addr;

    prev_wait  = imem_req && !imem_gnt;
    prev_addr  = imem_addr;
    expect_req = 0;
    if (redirect) begin
      epoch++;
      buf_cnt  = 0;
      exp_pc   = redirect_pc & ~32'h3;
      exp_addr = redirect_pc & ~32'h3;
      if (rv) void'(pend.pop_front());
      expect_req = (pend.size() == 0);
      prev_wait  = 0;
      capt_req = 1; capt_valid = 1;
      post_addr = 32'hDEAD_BEEF; post_pc = 32'hDEAD_BEEF;
    end else begin
      if (buf_cnt > 0 && !stall) begin
        buf_cnt--;
        exp_pc += 4;
        delivered++;
      end
      if (rv) begin
        r = pend.pop_front();
        if (r.epoch == epoch) buf_cnt++;
        else if (stale_count() == 0) expect_req = 1;
      end
      if (imem_req && imem_gnt) begin
        rdy = cyc + $urandom_range(max_lat, min_lat);
        if (rdy < last_ready) rdy = last_ready;
        last_ready = rdy;
        pend.push_back('{imem_addr, epoch, rdy});
        exp_addr += 4;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    int d0;
    delivered = 0; epoch = 0; force_redir = 0; capt_req = 0; capt_valid = 0;
    post_addr = 0; post_pc = 0; w_first_pc = 0; w_first_instr = 0; w_pend_addr = 0;

    // Reset, always-granting one-cycle memory: first request and first word.
    p_gnt = 100; p_stall = 0; p_redir = 0; min_lat = 1; max_lat = 1;
    do_reset(3);
    for (int k = 0; k < 12; k++) step();
    chk("t1_first_req_cycle", first_req_cyc, 1);
    chk("t1_first_valid_cycle", first_valid_cyc, 3);
    chk("t1_three_delivered", delivered >= 3, 1);

    // Wrap instance ran alongside: addresses roll over past 2^32.
    chk("t5_wrap_req_count", w_addrs.size() >= 3, 1);
    if (w_addrs.size() >= 3) begin
      chk("t5_wrap_addr0", w_addrs[0], 32'hFFFF_FFF8);
      chk("t5_wrap_addr1", w_addrs[1], 32'hFFFF_FFFC);
      chk("t5_wrap_addr2", w_addrs[2], 32'h0000_0000);
    end
    chk("t5_wrap_first_pc", w_first_pc, 32'hFFFF_FFF8);
    chk("t5_wrap_first_instr", w_first_instr, 32'hFFFF_0007);

    // Decode stalls for 5 cycles: buffer fills, requests stop, head holds.
    p_stall = 100;
    for (int k = 0; k < 5; k++) step();
    chk("t2_full_valid", instr_valid, 1);
    chk("t2_full_no_req", imem_req, 0);
    chk("t2_full_head", instr_pc, exp_pc);
    d0 = delivered;
    p_stall = 0;
    for (int k = 0; k < 10; k++) step();
    chk("t2_resume_delivers", (delivered - d0) >= 3, 1);

    // Redirect to 0x101 with two requests in flight.
    min_lat = 3; max_lat = 3;
    for (int k = 0; k < 20 && pend.size() != 2; k++) step();
    chk("t3_two_in_flight", pend.size(), 2);
    force_redir = 1; force_rpc = 32'h0000_0101;
    step();
    chk("t3_valid_after_redirect", instr_valid, 0);
    for (int k = 0; k < 20 && (capt_req || capt_valid); k++) step();
    chk("t3_next_addr", post_addr, 32'h0000_0100);
    chk("t3_next_pc", post_pc, 32'h0000_0100);

    // Redirect coinciding with a response while another request is in flight.
    min_lat = 2; max_lat = 2;
    for (int k = 0; k < 20 && !(pend.size() == 2 && pend[0].ready <= cyc); k++) step();
    chk("t4_setup", pend.size() == 2 && pend[0].ready <= cyc, 1);
    force_redir = 1; force_rpc = 32'h0000_2002;
    step();
    for (int k = 0; k < 20 && (capt_req || capt_valid); k++) step();
    chk("t4_next_addr", post_addr, 32'h0000_2000);
    chk("t4_next_pc", post_pc, 32'h0000_2000);

    // Reset asserted mid-burst with the buffer full.
    min_lat = 1; max_lat = 1; p_stall = 100;
    for (int k = 0; k < 20 && buf_cnt != 2; k++) step();
    chk("t6_buffer_full", buf_cnt, 2);
    rst_n = 1'b0;
    #1;
    chk("t6_valid_low", instr_valid, 0);
    chk("t6_req_low", imem_req, 0);
    chk("t6_addr_reset", imem_addr, 32'h0);

    // Random grants, latencies, stalls and redirects.
    p_gnt = 70; p_stall = 30; p_redir = 4; min_lat = 1; max_lat = 3;
    do_reset(2);
    d0 = delivered;
    for (int k = 0; k < 1500; k++) step();
    chk("rand_progress", (delivered - d0) > 100, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
